// File: rtl/word_unpack_2stage.sv
// word_unpack_2stage
//   Splits a 2*DATA_W word into two DATA_W bytes presented low byte first
//   over a Valid/Rdy handshake. A new word can be loaded on the same cycle
//   the high byte transfers, so back-to-back words stream with no gap.
//
// Ports
//   clock    rising-edge clock
//   rst      synchronous active-high reset
//   i_word   word to unpack, sampled on an accepted load
//   i_ld     load request
//   i_rdy    downstream ready
//   o_data   byte presented downstream (registered, 0 when idle)
//   o_valid  o_data is valid (registered)
//   o_busy   a word is held and not yet fully transferred
//   o_cnt    completely transferred words, modulo 256
//   o_par    (only with WORD_UNPACK_PARITY_EN) XOR reduction of o_data
//
// Optional feature macro: WORD_UNPACK_PARITY_EN adds the registered o_par port.
//
// state  | meaning
// S_IDLE | no word held, outputs quiet
// S_LO   | low byte presented
// S_HI   | high byte presented

module word_unpack_2stage #(
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   i_word,
  input  logic                  i_ld,
  input  logic                  i_rdy,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [7:0]            o_cnt
`ifdef WORD_UNPACK_PARITY_EN
  ,
  output logic                  o_par
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t                r_state;
  logic [2*DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic [7:0]            r_cnt;

  state_t                w_state_nxt;
  logic                  w_load;
  logic                  w_cnt_inc;
  logic [2*DATA_W-1:0]   w_hold_nxt;
  logic [DATA_W-1:0]     w_data_nxt;

  // Valid is 1 in both S_LO and S_HI, so a transfer there is just i_rdy.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_load      = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ld) begin
          w_load      = 1'b1;
          w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        w_state_nxt = i_rdy ? S_HI : S_LO;
      end
      S_HI: begin
        if (i_rdy) begin
          w_cnt_inc = 1'b1;
          // final-byte handoff: next word's low byte follows immediately
          if (i_ld) begin
            w_load      = 1'b1;
            w_state_nxt = S_LO;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_HI;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hold_nxt = w_load ? i_word : r_hold;

  // Outputs are registered from the next state so the low byte appears
  // on the cycle right after the load is accepted.
  always_comb begin
    w_data_nxt = '0;
    case (w_state_nxt)
      S_LO:    w_data_nxt = w_hold_nxt[DATA_W-1:0];
      S_HI:    w_data_nxt = w_hold_nxt[2*DATA_W-1:DATA_W];
      default: w_data_nxt = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_data  <= w_data_nxt;
      r_valid <= (w_state_nxt != S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_cnt   = r_cnt;

`ifdef WORD_UNPACK_PARITY_EN
  logic r_par;

  // w_data_nxt is already 0 when idle, so its parity is 0 there too.
  always_ff @(posedge clock) begin
    if (rst) r_par <= 1'b0;
    else     r_par <= ^w_data_nxt;
  end

  assign o_par = r_par;
`endif

endmodule

// File: tb/tb_word_unpack_2stage.sv
module tb_word_unpack_2stage;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] word  = 16'h0;
  logic        ld    = 1'b0;
  logic        rdy   = 1'b0;
  logic [7:0]  data;
  logic        valid;
  logic        busy;
  logic [7:0]  cnt;
`ifdef WORD_UNPACK_PARITY_EN
  logic        par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  word_unpack_2stage #(.DATA_W(8)) dut (
    .clock   (clock),
    .rst     (rst),
    .i_word  (word),
    .i_ld    (ld),
    .i_rdy   (rdy),
    .o_data  (data),
    .o_valid (valid),
    .o_busy  (busy),
    .o_cnt   (cnt)
`ifdef WORD_UNPACK_PARITY_EN
    ,
    .o_par   (par)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        ld;
    logic        rdy;
    logic [15:0] word;
    logic [7:0]  e_data;
    logic        e_valid;
    logic        e_busy;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the held word is a queue of bytes still to send.
  logic [7:0] mq[$];
  int         mcnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic l, input logic y, input logic [15:0] w);
    bit acc;
    if (r) begin
      mq.delete();
      mcnt = 0;
    end else begin
      acc = l && ((mq.size() == 0) || (mq.size() == 1 && y));
      if (mq.size() > 0 && y) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mcnt = (mcnt + 1) % 256;
      end
      if (acc) begin
        mq.push_back(w[7:0]);
        mq.push_back(w[15:8]);
      end
    end
  endtask

  task automatic drive_edge(input logic r, input logic l, input logic y, input logic [15:0] w);
    rst  = r;
    ld   = l;
    rdy  = y;
    word = w;
    @(posedge clock);
    #1;
    model_step(r, l, y, w);
  endtask

  task automatic model_step_check(input string tag, input logic r, input logic l,
                                  input logic y, input logic [15:0] w);
    logic [7:0] ed;
    drive_edge(r, l, y, w);
    ed = (mq.size() > 0) ? mq[0] : 8'h00;
    chk({tag, ".data"},  int'(data),  int'(ed));
    chk({tag, ".valid"}, int'(valid), int'(mq.size() > 0));
    chk({tag, ".busy"},  int'(busy),  int'(mq.size() > 0));
    chk({tag, ".cnt"},   int'(cnt),   mcnt);
`ifdef WORD_UNPACK_PARITY_EN
    chk({tag, ".par"},   int'(par),   int'(^ed));
`endif
  endtask

  function automatic void add(input string n, input logic r, input logic l, input logic y,
                              input logic [15:0] w, input logic [7:0] d, input logic v,
                              input logic b, input logic [7:0] c);
    vec_t t;
    t.name = n; t.rst = r; t.ld = l; t.rdy = y; t.word = w;
    t.e_data = d; t.e_valid = v; t.e_busy = b; t.e_cnt = c;
    vecs.push_back(t);
  endfunction

  initial begin
    //  name           rst ld rdy word      data  v  b  cnt
    add("reset",        1, 0, 0, 16'h0000, 8'h00, 0, 0, 8'd0);
    add("basic_lo",     0, 1, 1, 16'hA55A, 8'h5A, 1, 1, 8'd0);
    add("basic_hi",     0, 0, 1, 16'h0000, 8'hA5, 1, 1, 8'd0);
    add("basic_done",   0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd1);
    add("bp_lo",        0, 1, 0, 16'h1234, 8'h34, 1, 1, 8'd1);
    add("bp_hold1",     0, 0, 0, 16'h0000, 8'h34, 1, 1, 8'd1);
    add("bp_hold2",     0, 0, 0, 16'h0000, 8'h34, 1, 1, 8'd1);
    add("bp_hold3",     0, 0, 0, 16'h0000, 8'h34, 1, 1, 8'd1);
    add("bp_hi",        0, 0, 1, 16'h0000, 8'h12, 1, 1, 8'd1);
    add("bp_hi_hold",   0, 1, 0, 16'h7777, 8'h12, 1, 1, 8'd1);
    add("bp_done",      0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd2);
    add("b2b_lo1",      0, 1, 1, 16'h1234, 8'h34, 1, 1, 8'd2);
    add("b2b_hi1",      0, 0, 1, 16'h0000, 8'h12, 1, 1, 8'd2);
    add("b2b_lo2",      0, 1, 1, 16'hBEEF, 8'hEF, 1, 1, 8'd3);
    add("b2b_hi2",      0, 0, 1, 16'h0000, 8'hBE, 1, 1, 8'd3);
    add("b2b_done",     0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd4);
    add("ign_lo",       0, 1, 0, 16'h1234, 8'h34, 1, 1, 8'd4);
    add("ign_ld_hold",  0, 1, 0, 16'hFFFF, 8'h34, 1, 1, 8'd4);
    add("ign_ld_xfer",  0, 1, 1, 16'hFFFF, 8'h12, 1, 1, 8'd4);
    add("ign_done",     0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd5);
    add("ign_no_extra", 0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd5);
    add("par_lo",       0, 1, 1, 16'h5A5B, 8'h5B, 1, 1, 8'd5);
    add("par_hi",       0, 0, 1, 16'h0000, 8'h5A, 1, 1, 8'd5);
    add("par_done",     0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd6);
    add("mid_lo",       0, 1, 1, 16'h1234, 8'h34, 1, 1, 8'd6);
    add("mid_hi",       0, 0, 1, 16'h0000, 8'h12, 1, 1, 8'd6);
    add("mid_rst",      1, 1, 1, 16'h5555, 8'h00, 0, 0, 8'd0);
    add("mid_after",    0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd0);
    add("rst_ld",       1, 1, 1, 16'h9999, 8'h00, 0, 0, 8'd0);
    add("rst_ld_after", 0, 0, 1, 16'h0000, 8'h00, 0, 0, 8'd0);

    repeat (2) @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      drive_edge(vecs[i].rst, vecs[i].ld, vecs[i].rdy, vecs[i].word);
      chk({vecs[i].name, ".data"},  int'(data),  int'(vecs[i].e_data));
      chk({vecs[i].name, ".valid"}, int'(valid), int'(vecs[i].e_valid));
      chk({vecs[i].name, ".busy"},  int'(busy),  int'(vecs[i].e_busy));
      chk({vecs[i].name, ".cnt"},   int'(cnt),   int'(vecs[i].e_cnt));
`ifdef WORD_UNPACK_PARITY_EN
      chk({vecs[i].name, ".par"},   int'(par),   int'(^vecs[i].e_data));
`endif
    end

    // 256 back-to-back words: counter must come back around to 0.
    model_step_check("wrap_rst", 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 256; i++) begin
      model_step_check("wrap_ld", 1'b0, 1'b1, 1'b1, 16'(i * 16'd257 + 16'd3));
      model_step_check("wrap_hi", 1'b0, 1'b0, 1'b1, 16'h0);
    end
    chk("cnt_pre_wrap", int'(cnt), 255);
    model_step_check("wrap_last", 1'b0, 1'b0, 1'b1, 16'h0);
    chk("cnt_wrap", int'(cnt), 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      model_step_check("rand",
                       ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 9) < 6),
                       16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
